stream_mux_n: RTL and testbench

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes on every input and on the output. It succeeds the plain 16-bit 2:1 select mux in the datapath. It adds a channel count parameter, a round-robin arbitration mode beside direct select, and a one-entry output pipeline register with back-pressure. It sits between operand/result producers and a single consumer, such as the writeback or memory request path.

---
 rtl/stream_mux_n_if.sv | 28 ++
 rtl/stream_mux_n.sv | 105 ++++++++++
 tb/tb_stream_mux_n.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_n_if.sv
// Handshake bundle for stream_mux_n: N input channels, one registered output,
// plus the mode/sel controls. The mux uses the slave modport, the environment uses master.
interface stream_mux_n_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [WIDTH-1:0]          out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [SEL_W-1:0]          out_chan;

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_chan
   );

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_chan
   );
endinterface

// File: rtl/stream_mux_n.sv
// N-channel registered stream mux with direct-select and round-robin modes.
// Optional STREAM_MUX_XFER_CNT_EN adds a saturating 16-bit output handshake counter.
module stream_mux_n #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   stream_mux_n_if.slave bus
`ifdef STREAM_MUX_XFER_CNT_EN
   ,
   output logic [15:0]   xfer_cnt
`endif
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_chan_q, out_chan_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             out_valid_q, out_valid_d;
   logic             load_en;
   logic             cand_vld;
   logic [SEL_W-1:0] cand;
   logic [SEL_W-1:0] nxt;
   logic             xfer;

   assign load_en = !out_valid_q || bus.out_ready;

   // Candidate channel: sel in direct mode, first valid after rr_ptr otherwise
   always_comb begin
      cand_vld = 1'b0;
      cand     = '0;
      nxt      = '0;
      if (!bus.mode) begin
         if (int'(bus.sel) < CHANNELS) begin
            cand_vld = 1'b1;
            cand     = bus.sel;
         end
      end else begin
         for (int k = 1; k <= CHANNELS; k++) begin
            nxt = SEL_W'((int'(rr_ptr_q) + k) % CHANNELS);
            if (!cand_vld && bus.in_valid[nxt]) begin
               cand_vld = 1'b1;
               cand     = nxt;
            end
         end
      end
   end

   assign xfer = rst_n && cand_vld && bus.in_valid[cand] && load_en;

   always_comb begin
      bus.in_ready = '0;
      if (rst_n && cand_vld) bus.in_ready[cand] = load_en;
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_data_d  = bus.in_data[int'(cand)*WIDTH +: WIDTH];
         out_chan_d  = cand;
         out_valid_d = 1'b1;
         if (bus.mode) rr_ptr_d = cand;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= SEL_W'(CHANNELS - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
   assign bus.out_valid = out_valid_q;

`ifdef STREAM_MUX_XFER_CNT_EN
   logic [15:0] xfer_cnt_q, xfer_cnt_d;

   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      if (out_valid_q && bus.out_ready && xfer_cnt_q != 16'hFFFF) xfer_cnt_d = xfer_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xfer_cnt_q <= '0;
      else        xfer_cnt_q <= xfer_cnt_d;
   end

   assign xfer_cnt = xfer_cnt_q;
`endif
endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: a 4-channel and a 3-channel instance
// exercised with hand-computed expectations.
module tb_stream_mux_n;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   stream_mux_n_if #(.WIDTH(16), .CHANNELS(4)) ifa ();
   stream_mux_n_if #(.WIDTH(16), .CHANNELS(3)) ifb ();

`ifdef STREAM_MUX_XFER_CNT_EN
   logic [15:0] xfer_cnt_a;
   logic [15:0] xfer_cnt_b;
`endif

   stream_mux_n #(.WIDTH(16), .CHANNELS(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
`ifdef STREAM_MUX_XFER_CNT_EN
      ,
      .xfer_cnt (xfer_cnt_a)
`endif
   );

   stream_mux_n #(.WIDTH(16), .CHANNELS(3)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
`ifdef STREAM_MUX_XFER_CNT_EN
      ,
      .xfer_cnt (xfer_cnt_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      ifa.in_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      ifa.in_valid  = 4'hF;
      ifa.mode      = 1'b1;
      ifa.sel       = 2'd0;
      ifa.out_ready = 1'b1;
      ifb.in_data   = {16'hB002, 16'hB001, 16'hB000};
      ifb.in_valid  = 3'b000;
      ifb.mode      = 1'b0;
      ifb.sel       = 2'd0;
      ifb.out_ready = 1'b1;

      // Reset state, with inputs trying to transfer
      #23;
      chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
      chk("rst_out_data",  32'(ifa.out_data),  32'd0);
      chk("rst_out_chan",  32'(ifa.out_chan),  32'd0);
      chk("rst_in_ready",  32'(ifa.in_ready),  32'd0);
`ifdef STREAM_MUX_XFER_CNT_EN
      chk("rst_xfer_cnt",  32'(xfer_cnt_a),    32'd0);
`endif

      // Direct mode: in_ready follows sel even without in_valid
      ifa.in_valid = 4'h0;
      ifa.mode     = 1'b0;
      ifa.sel      = 2'd2;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("dir_rdy_noval", 32'(ifa.in_ready), 32'h4);
      tick();
      chk("dir_idle_valid", 32'(ifa.out_valid), 32'd0);

      ifa.in_data  = {16'hA003, 16'hBEEF, 16'hA001, 16'hA000};
      ifa.in_valid = 4'b0100;
      #1;
      chk("dir_in_ready", 32'(ifa.in_ready), 32'h4);
      tick();
      chk("dir_out_valid", 32'(ifa.out_valid), 32'd1);
      chk("dir_out_data",  32'(ifa.out_data),  32'hBEEF);
      chk("dir_out_chan",  32'(ifa.out_chan),  32'd2);

      // Round-robin, all channels valid: 0,1,2,3,0 back to back
      ifa.in_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      ifa.in_valid = 4'hF;
      ifa.mode     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("rr_in_ready%0d", i), 32'(ifa.in_ready), 32'(1 << (i % 4)));
         tick();
         chk($sformatf("rr_valid%0d", i), 32'(ifa.out_valid), 32'd1);
         chk($sformatf("rr_chan%0d", i),  32'(ifa.out_chan),  32'(i % 4));
         chk($sformatf("rr_data%0d", i),  32'(ifa.out_data),  32'hA000 + 32'(i % 4));
      end
      ifa.in_valid = 4'h0;
      tick();
      chk("pop_drop_valid", 32'(ifa.out_valid), 32'd0);
      chk("pop_hold_chan",  32'(ifa.out_chan),  32'd0);

      // Back-pressure: 0x1234 held for 3 stalled cycles
      ifa.mode     = 1'b0;
      ifa.sel      = 2'd1;
      ifa.in_data  = {16'hA003, 16'hA002, 16'h1234, 16'hA000};
      ifa.in_valid = 4'b0010;
      tick();
      chk("bp_load_data", 32'(ifa.out_data), 32'h1234);
      ifa.in_data   = {16'hA003, 16'hA002, 16'h5678, 16'hA000};
      ifa.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp_in_ready%0d", i), 32'(ifa.in_ready), 32'd0);
         tick();
         chk($sformatf("bp_valid%0d", i), 32'(ifa.out_valid), 32'd1);
         chk($sformatf("bp_data%0d", i),  32'(ifa.out_data),  32'h1234);
         chk($sformatf("bp_chan%0d", i),  32'(ifa.out_chan),  32'd1);
      end
      ifa.out_ready = 1'b1;
      #1;
      chk("bp_rel_ready", 32'(ifa.in_ready), 32'h2);
      tick();
      chk("bp_rel_data",  32'(ifa.out_data),  32'h5678);
      chk("bp_rel_valid", 32'(ifa.out_valid), 32'd1);
      ifa.in_valid = 4'h0;
      tick();

      // 3-channel instance: sel=3 is out of range
      ifb.in_valid = 3'b111;
      ifb.sel      = 2'd3;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk($sformatf("oor_in_ready%0d", i), 32'(ifb.in_ready), 32'd0);
         tick();
         chk($sformatf("oor_valid%0d", i), 32'(ifb.out_valid), 32'd0);
      end
      ifb.sel = 2'd2;
      #1;
      chk("c3_sel2_ready", 32'(ifb.in_ready), 32'h4);
      tick();
      chk("c3_sel2_data", 32'(ifb.out_data), 32'hB002);
      chk("c3_sel2_chan", 32'(ifb.out_chan), 32'd2);
      ifb.in_valid = 3'b000;

      // Reset pulse discards a held beat; RR restarts at channel 0
      ifa.sel       = 2'd3;
      ifa.in_data   = {16'h3333, 16'hA002, 16'hA001, 16'hA000};
      ifa.in_valid  = 4'b1000;
      ifa.out_ready = 1'b0;
      tick();
      chk("pre_rst_valid", 32'(ifa.out_valid), 32'd1);
      chk("pre_rst_chan",  32'(ifa.out_chan),  32'd3);
      ifa.in_valid = 4'h0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(ifa.out_valid), 32'd0);
      chk("arst_data",  32'(ifa.out_data),  32'd0);
      chk("arst_chan",  32'(ifa.out_chan),  32'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      ifa.in_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      ifa.mode      = 1'b1;
      ifa.in_valid  = 4'hF;
      ifa.out_ready = 1'b1;
      #1;
      chk("post_rst_ready", 32'(ifa.in_ready), 32'h1);
      tick();
      chk("post_rst_chan", 32'(ifa.out_chan), 32'd0);
      chk("post_rst_data", 32'(ifa.out_data), 32'hA000);

`ifdef STREAM_MUX_XFER_CNT_EN
      // One beat registered, none popped yet; next edge pops it
      tick();
      chk("cnt_first", 32'(xfer_cnt_a), 32'd1);
      repeat (65540) @(posedge clk);
      #1;
      chk("cnt_saturate", 32'(xfer_cnt_a), 32'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
